// File: rtl/tim_apb_master.sv
// tim_apb_master: APB4 requester for the timer's slave port.
// Takes one request at a time from a valid/ready request channel, runs a
// SETUP/ACCESS pair on the timer APB bus, waits on tim_pready and hands the
// result back on a valid/ready response channel. An 8-bit saturating wait
// counter aborts the ACCESS phase after TIMEOUT_CYCLES wait states.
//
// Ports:
//   sys_clk, sys_rst            clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_write/addr/wdata/strb   request payload
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata/err/timeout       response payload (rdata 0 on writes/timeouts)
//   tim_p*                      APB4 requester signals to the timer
module tim_apb_master #(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_strb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                tim_psel,
  output logic                tim_penable,
  output logic                tim_pwrite,
  output logic [ADDR_W-1:0]   tim_paddr,
  output logic [DATA_W-1:0]   tim_pwdata,
  output logic [DATA_W/8-1:0] tim_pstrb,
  input  logic [DATA_W-1:0]   tim_prdata,
  input  logic                tim_pready,
  input  logic                tim_pslverr
);
  localparam int         STRB_W = DATA_W / 8;
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
  } req_t;

  state_t     state, state_nxt;
  req_t       req_q;
  logic [7:0] wait_cnt, wait_inc;
  logic       accept, timed_out;

  // Counter saturates so a large TIMEOUT_CYCLES can never be skipped by wrap.
  assign wait_inc  = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
  // Only a wait state (pready low) can time out; pready on the limit edge wins.
  assign timed_out = (state == ACCESS) && !tim_pready && (wait_inc >= TO_LIM);
  assign accept    = req_valid && req_ready;

  // APB address/control/data come straight from the captured request so they
  // are stable for the whole SETUP+ACCESS window.
  assign tim_pwrite = req_q.write;
  assign tim_paddr  = req_q.addr;
  assign tim_pwdata = req_q.wdata;
  assign tim_pstrb  = req_q.strb;

  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    tim_psel    = 1'b0;
    tim_penable = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !sys_rst;
        if (accept) state_nxt = SETUP;
      end
      SETUP: begin
        tim_psel  = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        tim_psel    = 1'b1;
        tim_penable = 1'b1;
        if (tim_pready || timed_out) state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state       <= IDLE;
      req_q       <= '0;
      wait_cnt    <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            req_q.write <= req_write;
            req_q.addr  <= req_addr;
            req_q.wdata <= req_wdata;
            req_q.strb  <= req_write ? req_strb : '0;
          end
        end
        ACCESS: begin
          if (tim_pready) begin
            // pslverr is only meaningful alongside pready
            rsp_rdata   <= req_q.write ? '0 : tim_prdata;
            rsp_err     <= tim_pslverr;
            rsp_timeout <= 1'b0;
          end else begin
            wait_cnt <= wait_inc;
            if (timed_out) begin
              rsp_rdata   <= '0;
              rsp_err     <= 1'b1;
              rsp_timeout <= 1'b1;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_tim_apb_master.sv
// Directed bench for tim_apb_master: write, read, slave error, timeout,
// backpressure/back-to-back and reset during ACCESS. Outputs are sampled
// 1 time unit after the rising edge, where inputs are also driven.
module tb_tim_apb_master;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_strb = '0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout;
  logic        tim_psel, tim_penable, tim_pwrite;
  logic [11:0] tim_paddr;
  logic [31:0] tim_pwdata;
  logic [3:0]  tim_pstrb;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tim_apb_master #(.ADDR_W(12), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
    .sys_clk(clk), .sys_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .tim_psel(tim_psel), .tim_penable(tim_penable), .tim_pwrite(tim_pwrite),
    .tim_paddr(tim_paddr), .tim_pwdata(tim_pwdata), .tim_pstrb(tim_pstrb),
    .tim_prdata(prdata), .tim_pready(pready), .tim_pslverr(pslverr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and plays the slave: pready rises in ACCESS cycle
  // 'waits' (never if negative). Returns with the response pending.
  task automatic run_xfer(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                          input logic [3:0] sb, input int waits, input logic [31:0] rd,
                          input logic se, input logic pulse,
                          output int n_edges, output int n_setup, output int n_access,
                          output logic stable);
    int  k;
    bit  done;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_strb = sb;
    k = 0;
    while (!req_ready && k < 50) begin step(); k++; end
    checks++;
    if (req_ready !== 1'b1) begin
      $display("FAIL req_ready_wait got=%b want=1", req_ready); failures++;
    end
    step();
    req_valid = 1'b0;
    n_edges = 0; n_setup = 0; n_access = 0; stable = 1'b1; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      if (rsp_valid) done = 1'b1;
      else begin
        if (tim_psel) begin
          if (tim_paddr !== a || tim_pwrite !== wr || tim_pwdata !== wd ||
              tim_pstrb !== (wr ? sb : 4'h0)) stable = 1'b0;
          if (tim_penable) begin
            pready  = (n_access == waits);
            pslverr = pready ? se : pulse;
            prdata  = pready ? rd : 32'hDEAD_BEEF;
            n_access++;
          end else n_setup++;
        end
        step();
        n_edges++;
      end
    end
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    checks++;
    if (!done) begin $display("FAIL rsp_valid_wait got=0 want=1"); failures++; end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (req_ready !== 1'b0 || tim_psel !== 1'b0 || tim_penable !== 1'b0 || rsp_valid !== 1'b0 ||
        rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      $display("FAIL reset_ctrl got rdy=%b psel=%b pen=%b rv=%b err=%b to=%b want all 0",
               req_ready, tim_psel, tim_penable, rsp_valid, rsp_err, rsp_timeout);
      failures++;
    end
    checks++;
    if (tim_paddr !== 12'h0 || tim_pwdata !== 32'h0 || tim_pstrb !== 4'h0 || rsp_rdata !== 32'h0) begin
      $display("FAIL reset_data got paddr=%h pwdata=%h pstrb=%h rdata=%h want 0",
               tim_paddr, tim_pwdata, tim_pstrb, rsp_rdata);
      failures++;
    end
    rst = 1'b0;
    step();
    checks++;
    if (req_ready !== 1'b1) begin $display("FAIL idle_ready got=%b want=1", req_ready); failures++; end
  endtask

  task automatic test_write();
    int ne, ns, na; logic st;
    run_xfer(1'b1, 12'h000, 32'h0000_0001, 4'hF, 1, 32'hA5A5_A5A5, 1'b0, 1'b0, ne, ns, na, st);
    checks++;
    if (ne !== 3 || ns !== 1 || na !== 2) begin
      $display("FAIL write_latency got edges=%0d setup=%0d access=%0d want 3/1/2", ne, ns, na); failures++;
    end
    checks++;
    if (st !== 1'b1) begin $display("FAIL write_stable got=%b want=1", st); failures++; end
    checks++;
    if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0 || tim_psel !== 1'b0 || req_ready !== 1'b0) begin
      $display("FAIL write_rsp got err=%b to=%b rdata=%h psel=%b rdy=%b want 0/0/0/0/0",
               rsp_err, rsp_timeout, rsp_rdata, tim_psel, req_ready);
      failures++;
    end
    consume();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL write_consume got rv=%b rdy=%b want 0/1", rsp_valid, req_ready); failures++;
    end
  endtask

  task automatic test_read();
    int ne, ns, na; logic st;
    run_xfer(1'b0, 12'h00C, 32'h1234_0000, 4'hF, 2, 32'hFFFF_FFFF, 1'b0, 1'b0, ne, ns, na, st);
    checks++;
    if (ne !== 4 || na !== 3) begin
      $display("FAIL read_latency got edges=%0d access=%0d want 4/3", ne, na); failures++;
    end
    checks++;
    if (st !== 1'b1) begin $display("FAIL read_stable_strb0 got=%b want=1", st); failures++; end
    checks++;
    if (rsp_rdata !== 32'hFFFF_FFFF || rsp_err !== 1'b0) begin
      $display("FAIL read_rsp got rdata=%h err=%b want ffffffff/0", rsp_rdata, rsp_err); failures++;
    end
    consume();
  endtask

  task automatic test_error();
    int ne, ns, na; logic st;
    run_xfer(1'b0, 12'h100, 32'h0, 4'hF, 2, 32'h0BAD_0BAD, 1'b1, 1'b1, ne, ns, na, st);
    checks++;
    if (rsp_err !== 1'b1 || rsp_timeout !== 1'b0 || rsp_rdata !== 32'h0BAD_0BAD) begin
      $display("FAIL slverr_rsp got err=%b to=%b rdata=%h want 1/0/0bad0bad", rsp_err, rsp_timeout, rsp_rdata);
      failures++;
    end
    consume();
    // pslverr pulses during wait states only; completion is clean
    run_xfer(1'b0, 12'h100, 32'h0, 4'hF, 2, 32'h0000_5A5A, 1'b0, 1'b1, ne, ns, na, st);
    checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0000_5A5A) begin
      $display("FAIL slverr_ignored got err=%b rdata=%h want 0/00005a5a", rsp_err, rsp_rdata); failures++;
    end
    consume();
  endtask

  task automatic test_timeout();
    int ne, ns, na; logic st;
    run_xfer(1'b0, 12'h004, 32'h0, 4'h0, -1, 32'h0, 1'b0, 1'b0, ne, ns, na, st);
    checks++;
    if (na !== 16 || ne !== 17) begin
      $display("FAIL timeout_len got access=%0d edges=%0d want 16/17", na, ne); failures++;
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_timeout !== 1'b1 || rsp_rdata !== 32'h0 || tim_psel !== 1'b0) begin
      $display("FAIL timeout_rsp got err=%b to=%b rdata=%h psel=%b want 1/1/0/0",
               rsp_err, rsp_timeout, rsp_rdata, tim_psel);
      failures++;
    end
    consume();
    checks++;
    if (rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      $display("FAIL timeout_clear got err=%b to=%b want 0/0", rsp_err, rsp_timeout); failures++;
    end
    // pready arrives on the 16th ACCESS edge: completion beats the timeout
    run_xfer(1'b0, 12'h004, 32'h0, 4'h0, 15, 32'h00C0_FFEE, 1'b0, 1'b0, ne, ns, na, st);
    checks++;
    if (na !== 16 || rsp_timeout !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h00C0_FFEE) begin
      $display("FAIL timeout_edge got access=%0d to=%b err=%b rdata=%h want 16/0/0/00c0ffee",
               na, rsp_timeout, rsp_err, rsp_rdata);
      failures++;
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int ne, ns, na; logic st;
    logic [11:0] addrs [2];
    logic [11:0] got [4];
    int ng, idx, low_run, gap_min;
    bit seen_hi, acc;
    addrs[0] = 12'h014; addrs[1] = 12'h01C;
    run_xfer(1'b0, 12'h008, 32'h0, 4'h0, 0, 32'h0000_0008, 1'b0, 1'b0, ne, ns, na, st);
    req_valid = 1'b1; req_write = 1'b1; req_addr = addrs[0]; req_wdata = 32'h1; req_strb = 4'hF;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_ready !== 1'b0 || tim_psel !== 1'b0 || rsp_valid !== 1'b1) begin
        $display("FAIL backpressure_c%0d got rdy=%b psel=%b rv=%b want 0/0/1", i, req_ready, tim_psel, rsp_valid);
        failures++;
      end
      step();
    end
    rsp_ready = 1'b1; pready = 1'b1;
    ng = 0; idx = 0; low_run = 0; gap_min = 1000; seen_hi = 1'b0;
    for (int c = 0; c < 20; c++) begin
      acc = req_valid && req_ready;
      if (tim_psel) begin
        if (!tim_penable && ng < 4) begin got[ng] = tim_paddr; ng++; end
        if (seen_hi && low_run > 0 && low_run < gap_min) gap_min = low_run;
        seen_hi = 1'b1; low_run = 0;
      end else if (seen_hi) low_run++;
      step();
      if (acc) begin
        idx++;
        if (idx < 2) req_addr = addrs[idx];
        else req_valid = 1'b0;
      end
    end
    rsp_ready = 1'b0; pready = 1'b0;
    checks++;
    if (ng !== 2 || got[0] !== 12'h014 || got[1] !== 12'h01C) begin
      $display("FAIL b2b_order got n=%0d a0=%h a1=%h want 2/014/01c", ng, got[0], got[1]); failures++;
    end
    checks++;
    if (gap_min < 2 || gap_min == 1000) begin
      $display("FAIL b2b_gap got=%0d want>=2", gap_min); failures++;
    end
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_err !== 1'b0) begin
      $display("FAIL b2b_end got rv=%b rdy=%b err=%b want 0/1/0", rsp_valid, req_ready, rsp_err); failures++;
    end
  endtask

  task automatic test_reset_mid();
    int ne, ns, na; logic st;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 12'h010; req_strb = 4'h0;
    step();
    req_valid = 1'b0;
    step();
    checks++;
    if (tim_penable !== 1'b1) begin $display("FAIL mid_access got pen=%b want=1", tim_penable); failures++; end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (tim_psel !== 1'b0 || tim_penable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      $display("FAIL mid_reset got psel=%b pen=%b rv=%b rdy=%b want 0/0/0/1",
               tim_psel, tim_penable, rsp_valid, req_ready);
      failures++;
    end
    run_xfer(1'b0, 12'h000, 32'h0, 4'h0, 1, 32'h0000_0042, 1'b0, 1'b0, ne, ns, na, st);
    checks++;
    if (ne !== 3 || rsp_rdata !== 32'h0000_0042 || rsp_err !== 1'b0) begin
      $display("FAIL post_reset_read got edges=%0d rdata=%h err=%b want 3/00000042/0", ne, rsp_rdata, rsp_err);
      failures++;
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_error();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
